// File: rtl/nios2_pkg.sv
// Shared types and constants for the nios_2 instruction-fetch sequencer.
// Holds the fetch-state encoding, the NOP instruction word and default widths.
package nios2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT_PC = 3'd3,
        ST_HALTED  = 3'd4
    } fetch_state_e;

    // "add r0, r0, r0" encoding used as the architectural no-op
    localparam logic [31:0] NOP_INSN = 32'h0001_883a;

    localparam int DEF_AW          = 8;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_TIMEOUT_CYC = 16;

endpackage

// File: rtl/nios2_fetch_ctrl.sv
// Fetch/issue sequencer: fetches the word at the core PC over req/ack, pulses core enable once per instruction.
// Optional fetch-timeout abort is built when NIOS2_FETCH_TIMEOUT_EN is defined.
module nios2_fetch_ctrl
    import nios2_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int CNT_W = DEF_CNT_W
`ifdef NIOS2_FETCH_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             halt_i,
    input  logic [AW-1:0]    core_pc_i,
    output logic             core_enable_o,
    output logic [31:0]      core_inst_o,
    output logic             imem_req_o,
    output logic [AW-1:0]    imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [31:0]      imem_rdata_i,
    output logic             busy_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] inst_cnt_o,
    output logic             err_o
);

    fetch_state_e     state_r;
    fetch_state_e     state_s;
    logic             step_mode_r;
    logic [AW-1:0]    addr_r;
    logic [31:0]      inst_r;
    logic [CNT_W-1:0] cnt_r;
    logic             en_r;
    logic             req_r;
    logic             busy_r;
    logic             halted_r;
    logic             timeout_s;
    logic             abort_s;

`ifdef NIOS2_FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    logic [TW-1:0] tmo_r;
    logic          abort_r;
    logic          err_r;

    // Cycles spent in the current FETCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_r <= '0;
        end else if (state_r == ST_FETCH) begin
            tmo_r <= tmo_r + TW'(1);
        end else begin
            tmo_r <= '0;
        end
    end

    assign timeout_s = (state_r == ST_FETCH) && !imem_ack_i && (tmo_r == TW'(TIMEOUT_CYC - 1));

    // Abort marker (consumed in WAIT_PC) and the sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abort_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            if (timeout_s) begin
                abort_r <= 1'b1;
                err_r   <= 1'b1;
            end else if (state_r == ST_WAIT_PC) begin
                abort_r <= 1'b0;
            end
        end
    end

    assign abort_s = abort_r;
    assign err_o   = err_r;
`else
    assign timeout_s = 1'b0;
    assign abort_s   = 1'b0;
    assign err_o     = 1'b0;
`endif

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (halt_i) begin
                    state_s = ST_HALTED;
                end else if (run_i || step_i) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (imem_ack_i || timeout_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT_PC;
            end
            ST_WAIT_PC: begin
                if (halt_i || abort_s) begin
                    state_s = ST_HALTED;
                end else if (step_mode_r) begin
                    state_s = ST_IDLE;
                end else if (run_i) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HALTED: begin
                // a still-held run must not restart the core
                if (!halt_i && !run_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HALTED;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register, registered outputs, address/instruction latches and retired counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            step_mode_r <= 1'b0;
            addr_r      <= '0;
            inst_r      <= NOP_INSN;
            cnt_r       <= '0;
            en_r        <= 1'b0;
            req_r       <= 1'b0;
            busy_r      <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            en_r     <= (state_s == ST_ISSUE);
            req_r    <= (state_s == ST_FETCH);
            busy_r   <= (state_s != ST_IDLE) && (state_s != ST_HALTED);
            halted_r <= (state_s == ST_HALTED);
            if ((state_r == ST_IDLE) && (state_s == ST_FETCH)) begin
                step_mode_r <= !run_i;
            end
            if ((state_s == ST_FETCH) && (state_r != ST_FETCH)) begin
                addr_r <= core_pc_i;
            end
            if ((state_r == ST_FETCH) && imem_ack_i) begin
                inst_r <= imem_rdata_i;
            end else if (timeout_s) begin
                inst_r <= NOP_INSN;
            end
            if ((state_r == ST_ISSUE) && !(&cnt_r)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign core_enable_o = en_r;
    assign core_inst_o   = inst_r;
    assign imem_req_o    = req_r;
    assign imem_addr_o   = addr_r;
    assign busy_o        = busy_r;
    assign halted_o      = halted_r;
    assign inst_cnt_o    = cnt_r;

endmodule
